// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bundle between the two producers, the arbiter and the register-file write port.
// The master modport is the producer/observer side; the slave modport is the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int CNT_W = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [4:0]       req0_rd;
  logic [31:0]      req0_data;
  logic             req1_valid;
  logic             req1_ready;
  logic [4:0]       req1_rd;
  logic [31:0]      req1_data;
  logic             rf_wEn;
  logic [4:0]       rf_Rw;
  logic [31:0]      rf_busW;
  logic [31:0]      pend;
  logic [CNT_W-1:0] wr_cnt;

  modport master (
    output req0_valid, req0_rd, req0_data, req1_valid, req1_rd, req1_data,
    input  req0_ready, req1_ready, rf_wEn, rf_Rw, rf_busW, pend, wr_cnt
  );

  modport slave (
    input  req0_valid, req0_rd, req0_data, req1_valid, req1_rd, req1_data,
    output req0_ready, req1_ready, rf_wEn, rf_Rw, rf_busW, pend, wr_cnt
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-requester write-back arbiter with one holding slot per requester, same-register
// ordering by age, round-robin otherwise, and a per-register pending vector.
module regfile_wb_arbiter #(
  parameter bit DROP_R0 = 1'b1,
  parameter int CNT_W   = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  regfile_wb_arbiter_if.slave bus
);
  localparam int DATA_W = 32;

  logic [1:0]        full_p0;
  logic [4:0]        rd_p0   [2];
  logic [DATA_W-1:0] data_p0 [2];
  logic              older1_p0;
  logic              lastGrant_p0;

  logic              vld_p1;
  logic [4:0]        rw_p1;
  logic [DATA_W-1:0] busW_p1;
  logic [CNT_W-1:0]  wrCnt_p1;

  logic [1:0]        grant;
  logic [1:0]        ready;
  logic [1:0]        acc;
  logic              anyGrant;
  logic [4:0]        rdG;
  logic [DATA_W-1:0] dataG;
  logic [31:0]       pendV;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Same-register pairs go by age; otherwise alternate away from the last winner.
  always_comb begin
    grant = 2'b00;
    unique case (full_p0)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11: begin
        if (rd_p0[0] == rd_p0[1]) grant = older1_p0 ? 2'b10 : 2'b01;
        else                      grant = lastGrant_p0 ? 2'b01 : 2'b10;
      end
      default: grant = 2'b00;
    endcase
  end

  always_comb begin
    ready    = ~full_p0 | grant;
    acc      = {bus.req1_valid, bus.req0_valid} & ready;
    anyGrant = |grant;
    rdG      = grant[1] ? rd_p0[1]   : rd_p0[0];
    dataG    = grant[1] ? data_p0[1] : data_p0[0];
  end

  // ---- stage p0: holding slots ----
  always_ff @(posedge clk) begin
    if (acc[0]) begin
      rd_p0[0]   <= bus.req0_rd;
      data_p0[0] <= bus.req0_data;
    end
    if (acc[1]) begin
      rd_p0[1]   <= bus.req1_rd;
      data_p0[1] <= bus.req1_data;
    end
  end

  // ---- stage p1: register-file write port ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_p0      <= 2'b00;
      older1_p0    <= 1'b0;
      lastGrant_p0 <= 1'b1;
      vld_p1       <= 1'b0;
      rw_p1        <= '0;
      busW_p1      <= '0;
      wrCnt_p1     <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (acc[k])        full_p0[k] <= 1'b1;
        else if (grant[k]) full_p0[k] <= 1'b0;
      end
      // A lone load is younger than whatever the other slot holds; a joint load makes slot 0 older.
      if (acc[0])      older1_p0 <= !acc[1];
      else if (acc[1]) older1_p0 <= 1'b0;
      if (anyGrant) begin
        lastGrant_p0 <= grant[1];
        rw_p1        <= rdG;
        busW_p1      <= dataG;
      end
      vld_p1 <= anyGrant && !(DROP_R0 && (rdG == 5'd0));
      if (vld_p1) wrCnt_p1 <= satInc(wrCnt_p1);
    end
  end

  always_comb begin
    pendV = '0;
    for (int k = 0; k < 2; k++) begin
      if (full_p0[k]) pendV[rd_p0[k]] = 1'b1;
    end
    if (vld_p1)  pendV[rw_p1] = 1'b1;
    if (DROP_R0) pendV[0]     = 1'b0;
  end

  assign bus.req0_ready = ready[0];
  assign bus.req1_ready = ready[1];
  assign bus.rf_wEn     = vld_p1;
  assign bus.rf_Rw      = rw_p1;
  assign bus.rf_busW    = busW_p1;
  assign bus.pend       = pendV;
  assign bus.wr_cnt     = wrCnt_p1;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench: instance A drops R0 writes with a 16-bit counter, instance B
// commits R0 writes with a 4-bit counter; a register-file model logs commits.
module tb_regfile_wb_arbiter;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  regfile_wb_arbiter_if #(.CNT_W(16)) ifA ();
  regfile_wb_arbiter_if #(.CNT_W(4))  ifB ();

  regfile_wb_arbiter #(.DROP_R0(1'b1), .CNT_W(16)) dutA (.clk(clk), .rst_n(rst_n), .bus(ifA));
  regfile_wb_arbiter #(.DROP_R0(1'b0), .CNT_W(4))  dutB (.clk(clk), .rst_n(rst_n), .bus(ifB));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] rfA [32];
  logic [31:0] rfB [32];
  logic [4:0]  logA_rd[$];
  logic [31:0] logA_data[$];
  logic [4:0]  logB_rd[$];

  always @(posedge clk) begin
    if (ifA.rf_wEn) begin
      rfA[ifA.rf_Rw] <= ifA.rf_busW;
      logA_rd.push_back(ifA.rf_Rw);
      logA_data.push_back(ifA.rf_busW);
    end
    if (ifB.rf_wEn) begin
      rfB[ifB.rf_Rw] <= ifB.rf_busW;
      logB_rd.push_back(ifB.rf_Rw);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifA.req0_valid = 1'b0; ifA.req0_rd = '0; ifA.req0_data = '0;
    ifA.req1_valid = 1'b0; ifA.req1_rd = '0; ifA.req1_data = '0;
    ifB.req0_valid = 1'b0; ifB.req0_rd = '0; ifB.req0_data = '0;
    ifB.req1_valid = 1'b0; ifB.req1_rd = '0; ifB.req1_data = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    rst_n = 1'b1;
    logA_rd.delete();
    logA_data.delete();
    logB_rd.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    total++; if (ifA.rf_wEn !== 1'b0) begin bad++; $display("FAIL reset_wEn got=%0h exp=0", ifA.rf_wEn); end
    total++; if (ifA.rf_Rw !== 5'd0) begin bad++; $display("FAIL reset_Rw got=%0h exp=0", ifA.rf_Rw); end
    total++; if (ifA.rf_busW !== 32'd0) begin bad++; $display("FAIL reset_busW got=%0h exp=0", ifA.rf_busW); end
    total++; if (ifA.pend !== 32'd0) begin bad++; $display("FAIL reset_pend got=%0h exp=0", ifA.pend); end
    total++; if (ifA.wr_cnt !== 16'd0) begin bad++; $display("FAIL reset_wr_cnt got=%0h exp=0", ifA.wr_cnt); end
    total++; if ({ifA.req1_ready, ifA.req0_ready} !== 2'b11) begin bad++; $display("FAIL reset_ready got=%0b exp=11", {ifA.req1_ready, ifA.req0_ready}); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    ifA.req0_valid = 1'b1; ifA.req0_rd = 5'd5; ifA.req0_data = 32'hAA;
    tick();
    ifA.req0_valid = 1'b0;
    total++; if (ifA.pend !== 32'h20) begin bad++; $display("FAIL single_pend_acc got=%0h exp=20", ifA.pend); end
    total++; if (ifA.rf_wEn !== 1'b0) begin bad++; $display("FAIL single_wEn_early got=%0h exp=0", ifA.rf_wEn); end
    tick();
    total++; if ({ifA.rf_wEn, ifA.rf_Rw} !== {1'b1, 5'd5}) begin bad++; $display("FAIL single_issue got=%0b/%0d exp=1/5", ifA.rf_wEn, ifA.rf_Rw); end
    total++; if (ifA.rf_busW !== 32'hAA) begin bad++; $display("FAIL single_busW got=%0h exp=aa", ifA.rf_busW); end
    total++; if (ifA.pend !== 32'h20) begin bad++; $display("FAIL single_pend_issue got=%0h exp=20", ifA.pend); end
    tick();
    total++; if (ifA.rf_wEn !== 1'b0) begin bad++; $display("FAIL single_wEn_after got=%0h exp=0", ifA.rf_wEn); end
    total++; if (ifA.pend !== 32'd0) begin bad++; $display("FAIL single_pend_after got=%0h exp=0", ifA.pend); end
    total++; if (rfA[5] !== 32'hAA) begin bad++; $display("FAIL single_R5 got=%0h exp=aa", rfA[5]); end
    total++; if (ifA.wr_cnt !== 16'd1) begin bad++; $display("FAIL single_wr_cnt got=%0d exp=1", ifA.wr_cnt); end
  endtask

  task automatic test_contention();
    int i0, i1;
    logic f0, f1;
    logic [4:0]  expRd   [6] = '{5'd1, 5'd9, 5'd2, 5'd10, 5'd3, 5'd11};
    logic [31:0] expData [6] = '{32'h11, 32'h91, 32'h12, 32'h92, 32'h13, 32'h93};
    do_reset();
    i0 = 0; i1 = 0;
    for (int c = 0; c < 40 && logA_rd.size() < 6; c++) begin
      ifA.req0_valid = (i0 < 3); ifA.req0_rd = 5'(1 + i0); ifA.req0_data = 32'h11 + 32'(i0);
      ifA.req1_valid = (i1 < 3); ifA.req1_rd = 5'(9 + i1); ifA.req1_data = 32'h91 + 32'(i1);
      f0 = ifA.req0_valid && ifA.req0_ready;
      f1 = ifA.req1_valid && ifA.req1_ready;
      tick();
      if (f0) i0++;
      if (f1) i1++;
    end
    idle_inputs();
    tick();
    tick();
    total++; if (i0 != 3 || i1 != 3) begin bad++; $display("FAIL cont_accepts got=%0d/%0d exp=3/3", i0, i1); end
    total++; if (logA_rd.size() != 6) begin bad++; $display("FAIL cont_commits got=%0d exp=6", logA_rd.size()); end
    for (int k = 0; k < 6 && k < logA_rd.size(); k++) begin
      total++;
      if (logA_rd[k] !== expRd[k] || logA_data[k] !== expData[k]) begin
        bad++; $display("FAIL cont_order[%0d] got=%0d:%0h exp=%0d:%0h", k, logA_rd[k], logA_data[k], expRd[k], expData[k]);
      end
    end
    total++; if (ifA.wr_cnt !== 16'd6) begin bad++; $display("FAIL cont_wr_cnt got=%0d exp=6", ifA.wr_cnt); end
  endtask

  task automatic test_same_rd();
    do_reset();
    ifA.req1_valid = 1'b1; ifA.req1_rd = 5'd7; ifA.req1_data = 32'h100;
    tick();
    ifA.req1_valid = 1'b0;
    ifA.req0_valid = 1'b1; ifA.req0_rd = 5'd7; ifA.req0_data = 32'h200;
    total++; if (ifA.req0_ready !== 1'b1) begin bad++; $display("FAIL seq_ready0 got=%0h exp=1", ifA.req0_ready); end
    tick();
    ifA.req0_valid = 1'b0;
    repeat (4) tick();
    total++; if (rfA[7] !== 32'h200) begin bad++; $display("FAIL seq_R7 got=%0h exp=200", rfA[7]); end

    // Leave last grant on slot 0 so round-robin alone would favour slot 1.
    do_reset();
    ifA.req0_valid = 1'b1; ifA.req0_rd = 5'd4; ifA.req0_data = 32'h44;
    tick();
    ifA.req0_valid = 1'b0;
    repeat (3) tick();
    logA_data.delete();
    ifA.req0_valid = 1'b1; ifA.req0_rd = 5'd7; ifA.req0_data = 32'h200;
    ifA.req1_valid = 1'b1; ifA.req1_rd = 5'd7; ifA.req1_data = 32'h100;
    tick();
    ifA.req0_valid = 1'b0;
    ifA.req1_valid = 1'b0;
    repeat (4) tick();
    total++; if (rfA[7] !== 32'h100) begin bad++; $display("FAIL sim_R7 got=%0h exp=100", rfA[7]); end
    total++; if (logA_data.size() != 2) begin bad++; $display("FAIL sim_commits got=%0d exp=2", logA_data.size()); end
    else begin
      total++; if (logA_data[0] !== 32'h200) begin bad++; $display("FAIL sim_first got=%0h exp=200", logA_data[0]); end
    end
  endtask

  task automatic test_r0_drop();
    logic seen;
    do_reset();
    ifA.req0_valid = 1'b1; ifA.req0_rd = 5'd0; ifA.req0_data = 32'hDEAD;
    total++; if (ifA.req0_ready !== 1'b1) begin bad++; $display("FAIL drop_ready got=%0h exp=1", ifA.req0_ready); end
    tick();
    ifA.req0_valid = 1'b0;
    total++; if (ifA.pend !== 32'd0) begin bad++; $display("FAIL drop_pend got=%0h exp=0", ifA.pend); end
    seen = ifA.rf_wEn;
    repeat (4) begin tick(); seen = seen | ifA.rf_wEn; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL drop_wEn got=%0h exp=0", seen); end
    total++; if (ifA.wr_cnt !== 16'd0) begin bad++; $display("FAIL drop_wr_cnt got=%0d exp=0", ifA.wr_cnt); end
    total++; if (ifA.req0_ready !== 1'b1) begin bad++; $display("FAIL drop_released got=%0h exp=1", ifA.req0_ready); end

    do_reset();
    ifB.req0_valid = 1'b1; ifB.req0_rd = 5'd0; ifB.req0_data = 32'hBEEF;
    tick();
    ifB.req0_valid = 1'b0;
    total++; if (ifB.pend !== 32'd1) begin bad++; $display("FAIL keep_pend got=%0h exp=1", ifB.pend); end
    tick();
    total++; if ({ifB.rf_wEn, ifB.rf_Rw} !== {1'b1, 5'd0}) begin bad++; $display("FAIL keep_issue got=%0b/%0d exp=1/0", ifB.rf_wEn, ifB.rf_Rw); end
    repeat (3) tick();
    total++; if (logB_rd.size() != 1) begin bad++; $display("FAIL keep_pulses got=%0d exp=1", logB_rd.size()); end
    total++; if (ifB.wr_cnt !== 4'd1) begin bad++; $display("FAIL keep_wr_cnt got=%0d exp=1", ifB.wr_cnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ifA.req0_valid = 1'b1; ifA.req0_rd = 5'd12; ifA.req0_data = 32'hC;
    ifA.req1_valid = 1'b1; ifA.req1_rd = 5'd13; ifA.req1_data = 32'hD;
    tick();
    ifA.req0_rd = 5'd14; ifA.req0_data = 32'hE;
    ifA.req1_valid = 1'b0;
    tick();
    ifA.req0_valid = 1'b0;
    total++; if (ifA.rf_wEn !== 1'b1) begin bad++; $display("FAIL mid_pre_wEn got=%0h exp=1", ifA.rf_wEn); end
    logA_rd.delete();
    #3;
    rst_n = 1'b0;
    #1;
    total++; if ({ifA.rf_wEn, ifA.rf_Rw} !== 6'd0) begin bad++; $display("FAIL mid_wEn_Rw got=%0b/%0d exp=0/0", ifA.rf_wEn, ifA.rf_Rw); end
    total++; if (ifA.rf_busW !== 32'd0) begin bad++; $display("FAIL mid_busW got=%0h exp=0", ifA.rf_busW); end
    total++; if (ifA.pend !== 32'd0) begin bad++; $display("FAIL mid_pend got=%0h exp=0", ifA.pend); end
    total++; if (ifA.wr_cnt !== 16'd0) begin bad++; $display("FAIL mid_wr_cnt got=%0d exp=0", ifA.wr_cnt); end
    total++; if ({ifA.req1_ready, ifA.req0_ready} !== 2'b11) begin bad++; $display("FAIL mid_ready got=%0b exp=11", {ifA.req1_ready, ifA.req0_ready}); end
    #2;
    rst_n = 1'b1;
    repeat (4) tick();
    total++; if (logA_rd.size() != 0) begin bad++; $display("FAIL mid_stale got=%0d exp=0", logA_rd.size()); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      ifB.req0_valid = 1'b1; ifB.req0_rd = 5'(i + 1); ifB.req0_data = 32'(i);
      tick();
    end
    ifB.req0_valid = 1'b0;
    repeat (3) tick();
    total++; if (logB_rd.size() != 20) begin bad++; $display("FAIL sat_pulses got=%0d exp=20", logB_rd.size()); end
    total++; if (ifB.wr_cnt !== 4'd15) begin bad++; $display("FAIL sat_wr_cnt got=%0d exp=15", ifB.wr_cnt); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_contention();
    test_same_rd();
    test_r0_drop();
    test_reset_mid();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
